// File: rtl/fluxo_dados_drone_pkg.sv
// Shared definitions for the drone-game datapath: default geometry, obstacle
// map, per-mode wait lengths, mode encodings and a small lives helper.
package fluxo_dados_drone_pkg;

  localparam int          N_LINHAS_DEF = 4;
  localparam int          MAP_LEN_DEF  = 16;
  localparam logic [63:0] MAPA_DEF     = 64'h0400_2000_0100_0000;
  localparam int          T_LENTO_DEF  = 1000;
  localparam int          T_RAPIDO_DEF = 500;
  localparam int          T_W_DEF      = 16;

  localparam logic MODO_LENTO  = 1'b0;
  localparam logic MODO_RAPIDO = 1'b1;

  // A lives selector of zero would end the game before it starts, so it loads one life.
  function automatic logic [1:0] vidas_carga(input logic [1:0] sel);
    return (sel == 2'd0) ? 2'd1 : sel;
  endfunction

endpackage

// File: rtl/fluxo_dados_drone_timer_espera.sv
// Saturating wait timer.
//  clock, reset : clock, asynchronous active-high reset
//  zera         : clear to zero (wins over conta)
//  conta        : count enable, stops once the count reaches limite
//  limite       : terminal count (T-1)
//  fim          : count == limite; stays high until zera
module timer_espera
  import fluxo_dados_drone_pkg::*;
#(
  parameter int T_W = T_W_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           zera,
  input  logic           conta,
  input  logic [T_W-1:0] limite,
  output logic           fim
);

  logic [T_W-1:0] r_cnt;

  // Count register: clear, count up to the limit, then hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= {T_W{1'b0}};
    end else if (zera) begin
      r_cnt <= {T_W{1'b0}};
    end else if (conta && (r_cnt < limite)) begin
      r_cnt <= r_cnt + {{(T_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign fim = (r_cnt == limite);

endmodule

// File: rtl/fluxo_dados_drone.sv
// Datapath for the drone game: executes the control FSM's strobes and
// returns fim_espera / fim_mapa / colisao.
//  Inputs : clock, reset, zeraPosicoes, contaT, zeraT, escolhe_modo,
//           escolhe_vida, move_drone, desloca_horizontal, resetaVidas,
//           sel_modo, sel_vidas[1:0], botao_cima, botao_baixo
//  Outputs: fim_espera, fim_mapa, colisao, drone_y[Y_W-1:0],
//           coluna[C_W-1:0], vidas[1:0], modo
module fluxo_dados_drone
  import fluxo_dados_drone_pkg::*;
#(
  parameter int                              N_LINHAS = N_LINHAS_DEF,
  parameter int                              MAP_LEN  = MAP_LEN_DEF,
  parameter logic [N_LINHAS*MAP_LEN-1:0]     MAPA     = MAPA_DEF,
  parameter int                              T_LENTO  = T_LENTO_DEF,
  parameter int                              T_RAPIDO = T_RAPIDO_DEF,
  parameter int                              T_W      = T_W_DEF,
  localparam int                             Y_W      = $clog2(N_LINHAS),
  localparam int                             C_W      = $clog2(MAP_LEN)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           zeraPosicoes,
  input  logic           contaT,
  input  logic           zeraT,
  input  logic           escolhe_modo,
  input  logic           escolhe_vida,
  input  logic           move_drone,
  input  logic           desloca_horizontal,
  input  logic           resetaVidas,
  input  logic           sel_modo,
  input  logic [1:0]     sel_vidas,
  input  logic           botao_cima,
  input  logic           botao_baixo,
  output logic           fim_espera,
  output logic           fim_mapa,
  output logic           colisao,
  output logic [Y_W-1:0] drone_y,
  output logic [C_W-1:0] coluna,
  output logic [1:0]     vidas,
  output logic           modo
);

  localparam logic [Y_W-1:0] Y_INICIO = Y_W'(N_LINHAS / 2);
  localparam logic [Y_W-1:0] Y_MAX    = Y_W'(N_LINHAS - 1);
  localparam logic [C_W-1:0] C_MAX    = C_W'(MAP_LEN - 1);

  logic [Y_W-1:0] r_drone_y, w_drone_y_nxt;
  logic [C_W-1:0] r_coluna, w_coluna_nxt, w_nc;
  logic [1:0]     r_vidas, w_vidas_nxt;
  logic           r_modo, w_modo_nxt;
  logic           r_colisao, w_colisao_nxt;
  logic           r_cima_d, r_baixo_d;
  logic           w_edge_cima, w_edge_baixo, w_hit;
  logic [T_W-1:0] w_limite;

  // Terminal count follows the currently latched mode.
  assign w_limite = (r_modo == MODO_RAPIDO) ? T_W'(T_RAPIDO - 1) : T_W'(T_LENTO - 1);

  timer_espera #(.T_W(T_W)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .zera   (zeraT),
    .conta  (contaT),
    .limite (w_limite),
    .fim    (fim_espera)
  );

  // Next-state logic for position, lives, mode and collision flag.
  always_comb begin
    w_edge_cima  = botao_cima & ~r_cima_d;
    w_edge_baixo = botao_baixo & ~r_baixo_d;
    w_nc         = (r_coluna == C_MAX) ? r_coluna : r_coluna + C_W'(1);
    // Obstacle lookup uses the row held before any same-cycle move.
    w_hit        = desloca_horizontal & ~zeraPosicoes & MAPA[{w_nc, r_drone_y}];

    w_drone_y_nxt = r_drone_y;
    if (zeraPosicoes) begin
      w_drone_y_nxt = Y_INICIO;
    end else if (move_drone && w_edge_cima && !w_edge_baixo && (r_drone_y != Y_MAX)) begin
      w_drone_y_nxt = r_drone_y + Y_W'(1);
    end else if (move_drone && w_edge_baixo && !w_edge_cima && (r_drone_y != Y_W'(0))) begin
      w_drone_y_nxt = r_drone_y - Y_W'(1);
    end else begin
      w_drone_y_nxt = r_drone_y;
    end

    w_coluna_nxt  = r_coluna;
    w_colisao_nxt = r_colisao;
    if (zeraPosicoes) begin
      w_coluna_nxt  = {C_W{1'b0}};
      w_colisao_nxt = 1'b0;
    end else if (desloca_horizontal) begin
      w_coluna_nxt  = w_nc;
      w_colisao_nxt = w_hit && (r_vidas <= 2'd1);
    end else begin
      w_coluna_nxt  = r_coluna;
      w_colisao_nxt = r_colisao;
    end

    // Explicit lives loads take precedence over a hit in the same cycle.
    w_vidas_nxt = r_vidas;
    if (resetaVidas) begin
      w_vidas_nxt = 2'd1;
    end else if (escolhe_vida) begin
      w_vidas_nxt = vidas_carga(sel_vidas);
    end else if (w_hit) begin
      w_vidas_nxt = (r_vidas > 2'd1) ? r_vidas - 2'd1 : 2'd0;
    end else begin
      w_vidas_nxt = r_vidas;
    end

    w_modo_nxt = escolhe_modo ? sel_modo : r_modo;
  end

  // State registers, including the button edge-detect history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drone_y <= Y_INICIO;
      r_coluna  <= {C_W{1'b0}};
      r_vidas   <= 2'd1;
      r_modo    <= MODO_LENTO;
      r_colisao <= 1'b0;
      r_cima_d  <= 1'b0;
      r_baixo_d <= 1'b0;
    end else begin
      r_drone_y <= w_drone_y_nxt;
      r_coluna  <= w_coluna_nxt;
      r_vidas   <= w_vidas_nxt;
      r_modo    <= w_modo_nxt;
      r_colisao <= w_colisao_nxt;
      r_cima_d  <= botao_cima;
      r_baixo_d <= botao_baixo;
    end
  end

  assign drone_y  = r_drone_y;
  assign coluna   = r_coluna;
  assign vidas    = r_vidas;
  assign modo     = r_modo;
  assign colisao  = r_colisao;
  assign fim_mapa = (r_coluna == C_MAX);

endmodule

// File: tb/tb_fluxo_dados_drone.sv
module tb_fluxo_dados_drone;

  localparam logic [63:0] TB_MAPA = 64'h0000_0000_0000_0040; // column 1, row 2
  localparam int TL = 4;
  localparam int TR = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       zeraPosicoes, contaT, zeraT, escolhe_modo, escolhe_vida;
  logic       move_drone, desloca_horizontal, resetaVidas, sel_modo;
  logic [1:0] sel_vidas;
  logic       botao_cima, botao_baixo;
  logic       fim_espera, fim_mapa, colisao, modo;
  logic [1:0] drone_y;
  logic [3:0] coluna;
  logic [1:0] vidas;

  int total = 0;
  int bad   = 0;

  int m_y, m_col, m_vid, m_modo, m_t, m_colis, m_pc, m_pb;

  typedef struct {
    int y; int col; int vid; int modo; int colis; int fe; int fm;
  } exp_t;
  exp_t sb[$];

  fluxo_dados_drone #(
    .N_LINHAS(4), .MAP_LEN(16), .MAPA(TB_MAPA),
    .T_LENTO(TL), .T_RAPIDO(TR), .T_W(16)
  ) dut (
    .clock(clock), .reset(reset),
    .zeraPosicoes(zeraPosicoes), .contaT(contaT), .zeraT(zeraT),
    .escolhe_modo(escolhe_modo), .escolhe_vida(escolhe_vida),
    .move_drone(move_drone), .desloca_horizontal(desloca_horizontal),
    .resetaVidas(resetaVidas), .sel_modo(sel_modo), .sel_vidas(sel_vidas),
    .botao_cima(botao_cima), .botao_baixo(botao_baixo),
    .fim_espera(fim_espera), .fim_mapa(fim_mapa), .colisao(colisao),
    .drone_y(drone_y), .coluna(coluna), .vidas(vidas), .modo(modo)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 2; m_col = 0; m_vid = 1; m_modo = 0; m_t = 0; m_colis = 0; m_pc = 0; m_pb = 0;
  endtask

  task automatic strobes_off();
    zeraPosicoes = 0; contaT = 0; zeraT = 0; escolhe_modo = 0; escolhe_vida = 0;
    desloca_horizontal = 0; resetaVidas = 0;
  endtask

  // Advance the reference model by one clock and queue the expected outputs.
  task automatic push_expected();
    int lim, nc, hit, ec, eb, ny, nv;
    exp_t e;
    lim = (m_modo != 0) ? TR - 1 : TL - 1;
    if (zeraT) m_t = 0;
    else if (contaT && m_t < lim) m_t = m_t + 1;
    ec = (botao_cima && !m_pc) ? 1 : 0;
    eb = (botao_baixo && !m_pb) ? 1 : 0;
    m_pc = botao_cima ? 1 : 0;
    m_pb = botao_baixo ? 1 : 0;
    nc = (m_col == 15) ? 15 : m_col + 1;
    hit = (desloca_horizontal && !zeraPosicoes && TB_MAPA[nc*4 + m_y]) ? 1 : 0;
    ny = m_y;
    if (zeraPosicoes) ny = 2;
    else if (move_drone && ec && !eb) ny = (m_y < 3) ? m_y + 1 : 3;
    else if (move_drone && eb && !ec) ny = (m_y > 0) ? m_y - 1 : 0;
    if (zeraPosicoes) begin
      m_col = 0; m_colis = 0;
    end else if (desloca_horizontal) begin
      m_col = nc; m_colis = (hit && m_vid <= 1) ? 1 : 0;
    end
    nv = m_vid;
    if (resetaVidas) nv = 1;
    else if (escolhe_vida) nv = (sel_vidas == 0) ? 1 : int'(sel_vidas);
    else if (hit) nv = (m_vid > 1) ? m_vid - 1 : 0;
    m_vid = nv;
    m_y = ny;
    if (escolhe_modo) m_modo = sel_modo ? 1 : 0;
    e.y = m_y; e.col = m_col; e.vid = m_vid; e.modo = m_modo; e.colis = m_colis;
    e.fe = (m_t == ((m_modo != 0) ? TR - 1 : TL - 1)) ? 1 : 0;
    e.fm = (m_col == 15) ? 1 : 0;
    sb.push_back(e);
  endtask

  // One clock: queue the expectation, let the DUT react, pop and compare.
  task automatic cycle();
    exp_t e;
    push_expected();
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_val("sb_drone_y", drone_y, e.y);
    check_val("sb_coluna", coluna, e.col);
    check_val("sb_vidas", vidas, e.vid);
    check_val("sb_modo", modo, e.modo);
    check_val("sb_colisao", colisao, e.colis);
    check_val("sb_fim_espera", fim_espera, e.fe);
    check_val("sb_fim_mapa", fim_mapa, e.fm);
    strobes_off();
  endtask

  task automatic press_up();
    botao_cima = 1; cycle(); botao_cima = 0; cycle();
  endtask

  task automatic press_down();
    botao_baixo = 1; cycle(); botao_baixo = 0; cycle();
  endtask

  initial begin
    strobes_off();
    move_drone = 0; sel_modo = 0; sel_vidas = 2'd0; botao_cima = 0; botao_baixo = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    check_val("rst_drone_y", drone_y, 2);
    check_val("rst_coluna", coluna, 0);
    check_val("rst_vidas", vidas, 1);
    check_val("rst_modo", modo, 0);
    check_val("rst_colisao", colisao, 0);
    check_val("rst_fim_espera", fim_espera, 0);

    // Reset in the middle of a game.
    escolhe_vida = 1; sel_vidas = 2'd2; cycle();
    move_drone = 1; press_down(); move_drone = 0;
    repeat (5) begin desloca_horizontal = 1; cycle(); end
    escolhe_modo = 1; sel_modo = 1; cycle();
    check_val("mid_coluna", coluna, 5);
    check_val("mid_vidas", vidas, 2);
    @(negedge clock);
    reset = 1;
    #1;
    model_reset();
    check_val("rst2_drone_y", drone_y, 2);
    check_val("rst2_coluna", coluna, 0);
    check_val("rst2_vidas", vidas, 1);
    check_val("rst2_modo", modo, 0);
    check_val("rst2_colisao", colisao, 0);
    @(negedge clock);
    reset = 0;

    // Timer in slow mode: fim_espera after three counts, then held.
    contaT = 1; cycle();
    contaT = 1; cycle();
    contaT = 1; cycle();
    check_val("timer_fim", fim_espera, 1);
    repeat (3) begin contaT = 1; cycle(); end
    check_val("timer_hold", fim_espera, 1);
    zeraT = 1; contaT = 1; cycle();
    check_val("timer_zera_wins", fim_espera, 0);
    // Fast mode uses the shorter limit.
    escolhe_modo = 1; sel_modo = 1; cycle();
    repeat (4) begin contaT = 1; cycle(); end
    zeraT = 1; cycle();
    escolhe_modo = 1; sel_modo = 0; cycle();

    // Button moves.
    move_drone = 1;
    repeat (3) press_up();
    check_val("up_saturate", drone_y, 3);
    botao_cima = 1; botao_baixo = 1; cycle();
    botao_cima = 0; botao_baixo = 0; cycle();
    check_val("both_edges", drone_y, 3);
    move_drone = 0;
    press_down();
    check_val("move_disabled", drone_y, 3);
    move_drone = 1;
    repeat (4) press_down();
    check_val("down_saturate", drone_y, 0);
    botao_baixo = 1; repeat (3) cycle(); botao_baixo = 0; cycle();
    check_val("level_no_repeat", drone_y, 0);
    move_drone = 0;

    // Hit with two lives, then with one.
    zeraPosicoes = 1; cycle();
    escolhe_vida = 1; sel_vidas = 2'd2; cycle();
    desloca_horizontal = 1; cycle();
    check_val("hit2_coluna", coluna, 1);
    check_val("hit2_vidas", vidas, 1);
    check_val("hit2_colisao", colisao, 0);
    zeraPosicoes = 1; cycle();
    desloca_horizontal = 1; cycle();
    check_val("hit1_vidas", vidas, 0);
    check_val("hit1_colisao", colisao, 1);
    zeraPosicoes = 1; cycle();
    check_val("zera_clears_colisao", colisao, 0);
    check_val("zera_keeps_vidas", vidas, 0);
    zeraPosicoes = 1; resetaVidas = 1; cycle();
    check_val("zera_and_reseta", vidas, 1);
    escolhe_vida = 1; sel_vidas = 2'd0; cycle();
    check_val("sel_vidas_zero", vidas, 1);

    // Run to the end of the map on a clear row.
    move_drone = 1; press_down(); press_down(); move_drone = 0;
    repeat (15) begin desloca_horizontal = 1; cycle(); end
    check_val("map_end_coluna", coluna, 15);
    check_val("map_end_fim", fim_mapa, 1);
    desloca_horizontal = 1; cycle();
    check_val("map_end_sat", coluna, 15);

    // Mixed random traffic; lives loads never share a cycle with desloca.
    for (int i = 0; i < 400; i++) begin
      zeraPosicoes       = ($urandom_range(0, 15) == 0);
      contaT             = $urandom_range(0, 1);
      zeraT              = ($urandom_range(0, 7) == 0);
      escolhe_modo       = ($urandom_range(0, 15) == 0);
      sel_modo           = $urandom_range(0, 1);
      move_drone         = $urandom_range(0, 1);
      desloca_horizontal = ($urandom_range(0, 3) == 0);
      escolhe_vida       = !desloca_horizontal && ($urandom_range(0, 7) == 0);
      resetaVidas        = !desloca_horizontal && ($urandom_range(0, 15) == 0);
      sel_vidas          = 2'($urandom_range(0, 3));
      botao_cima         = $urandom_range(0, 1);
      botao_baixo        = $urandom_range(0, 1);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
